// File: rtl/d_fifo_sink.sv
// Sink for two destination FIFOs: round-robin pops, one-cycle-later capture of
// the read word, per-channel saturating word counters and an IDLE/ACTIVE/PAUSED FSM.
module d_fifo_sink #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_d0,
    input  logic                  fifo_empty_d1,
    input  logic [DATA_WIDTH-1:0] data_out_0,
    input  logic [DATA_WIDTH-1:0] data_out_1,
    input  logic                  hold,
    output logic                  pop_d0,
    output logic                  pop_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  dest_out,
    output logic [CNT_WIDTH-1:0]  count_d0,
    output logic [CNT_WIDTH-1:0]  count_d1,
    output logic [1:0]            state_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;        // 1 = D1 served last
    logic                    pend_q, pend_d;
    logic                    pend_ch_q, pend_ch_d;
    logic                    valid_q, valid_d;
    logic                    dest_q, dest_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_WIDTH-1:0]    cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]    cnt1_q, cnt1_d;

    logic grant_d0, grant_d1, pop_any, both_empty;

    // Round-robin grant; pops are combinational from current-cycle inputs
    always_comb begin
        grant_d0   = !fifo_empty_d0 && (fifo_empty_d1 || last_q);
        grant_d1   = !fifo_empty_d1 && (fifo_empty_d0 || !last_q);
        pop_d0     = !reset && !hold && !fifo_empty_d0 && grant_d0;
        pop_d1     = !reset && !hold && !fifo_empty_d1 && grant_d1;
        pop_any    = pop_d0 || pop_d1;
        both_empty = fifo_empty_d0 && fifo_empty_d1;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pend_d    = pop_any;
        pend_ch_d = pop_any ? pop_d1 : pend_ch_q;
        valid_d   = pend_q;
        dest_d    = dest_q;
        data_d    = data_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;

        if (pop_any) begin
            last_d = pop_d1;
        end

        // Capture the word popped last cycle; FIFO data is valid now
        if (pend_q) begin
            dest_d = pend_ch_q;
            if (pend_ch_q) begin
                data_d = data_out_1;
                if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_WIDTH'(1);
            end else begin
                data_d = data_out_0;
                if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pop_any) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (hold) begin
                    state_d = ST_PAUSED;
                end else if (!pop_any && !pend_q && both_empty) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSED: begin
                if (!hold) begin
                    // A leftover pending word with both FIFOs empty drains via ACTIVE
                    if (!both_empty || pend_q) state_d = ST_ACTIVE;
                    else                       state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            pend_q    <= 1'b0;
            pend_ch_q <= 1'b0;
            valid_q   <= 1'b0;
            dest_q    <= 1'b0;
            data_q    <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            pend_ch_q <= pend_ch_d;
            valid_q   <= valid_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign dest_out  = dest_q;
    assign count_d0  = cnt0_q;
    assign count_d1  = cnt1_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_d_fifo_sink.sv
// Directed bench for d_fifo_sink: inputs change on the falling edge, outputs are
// checked 1 time unit later against hand-computed expectations.
module tb_d_fifo_sink;

    localparam int unsigned DW = 6;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty_d0 = 1'b1;
    logic          fifo_empty_d1 = 1'b1;
    logic [DW-1:0] data_out_0 = '0;
    logic [DW-1:0] data_out_1 = '0;
    logic          hold = 1'b0;
    logic          pop_d0, pop_d1;
    logic [DW-1:0] data_out;
    logic          valid_out, dest_out;
    logic [CW-1:0] count_d0, count_d1;
    logic [1:0]    state_out;

    int n_tests = 0;
    int n_fail  = 0;

    d_fifo_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .fifo_empty_d0(fifo_empty_d0), .fifo_empty_d1(fifo_empty_d1),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .hold(hold),
        .pop_d0(pop_d0), .pop_d1(pop_d1), .data_out(data_out),
        .valid_out(valid_out), .dest_out(dest_out),
        .count_d0(count_d0), .count_d1(count_d1), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus, applied on the falling edge; settles before checks
    task automatic drive(input logic r, input logic h, input logic e0, input logic e1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clk);
        reset = r; hold = h; fifo_empty_d0 = e0; fifo_empty_d1 = e1;
        data_out_0 = d0; data_out_1 = d1;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
    endtask

    initial begin
        // Reset with both FIFOs non-empty
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h3F, 6'h3F);
        chk("rst_pop0", 32'(pop_d0), 0);
        chk("rst_pop1", 32'(pop_d1), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_dest", 32'(dest_out), 0);
        chk("rst_cnt0", 32'(count_d0), 0);
        chk("rst_cnt1", 32'(count_d1), 0);
        chk("rst_state", 32'(state_out), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);

        // Single word from D0
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("sw_pop0", 32'(pop_d0), 1);
        chk("sw_pop1", 32'(pop_d1), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'b101100, '0);
        chk("sw_pop0_off", 32'(pop_d0), 0);
        chk("sw_valid_early", 32'(valid_out), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("sw_valid", 32'(valid_out), 1);
        chk("sw_data", 32'(data_out), 32'b101100);
        chk("sw_dest", 32'(dest_out), 0);
        chk("sw_cnt0", 32'(count_d0), 1);
        chk("sw_state_act", 32'(state_out), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("sw_valid_off", 32'(valid_out), 0);
        chk("sw_data_hold", 32'(data_out), 32'b101100);
        chk("sw_state_idle", 32'(state_out), 0);

        // Round-robin with both FIFOs non-empty for 6 cycles
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b0, (k >= 6), (k >= 6), DW'(k + 8), DW'(k + 40));
            chk($sformatf("arb_pop0_%0d", k), 32'(pop_d0), 32'((k < 6) && (k % 2 == 0)));
            chk($sformatf("arb_pop1_%0d", k), 32'(pop_d1), 32'((k < 6) && (k % 2 == 1)));
            if (k >= 2 && k < 8) begin
                chk($sformatf("arb_valid_%0d", k), 32'(valid_out), 1);
                chk($sformatf("arb_dest_%0d", k), 32'(dest_out), 32'((k - 2) % 2));
                chk($sformatf("arb_data_%0d", k), 32'(data_out),
                    ((k - 2) % 2 == 1) ? 32'(k - 1 + 40) : 32'(k - 1 + 8));
            end
        end
        chk("arb_valid_end", 32'(valid_out), 0);
        chk("arb_cnt0", 32'(count_d0), 3);
        chk("arb_cnt1", 32'(count_d1), 3);

        // Hold rises the cycle after a pop and stays 4 cycles
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("hd_pop0_c0", 32'(pop_d0), 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'h2A, '0);
        chk("hd_pop0_c1", 32'(pop_d0), 0);
        chk("hd_state_c1", 32'(state_out), 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        chk("hd_pop0_c2", 32'(pop_d0), 0);
        chk("hd_state_c2", 32'(state_out), 2);
        chk("hd_valid_c2", 32'(valid_out), 1);
        chk("hd_data_c2", 32'(data_out), 32'h2A);
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        chk("hd_valid_c3", 32'(valid_out), 0);
        chk("hd_pop0_c3", 32'(pop_d0), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0);
        chk("hd_state_c4", 32'(state_out), 2);
        chk("hd_pop0_c4", 32'(pop_d0), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("hd_pop0_c5", 32'(pop_d0), 1);
        chk("hd_state_c5", 32'(state_out), 2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'h15, '0);
        chk("hd_state_c6", 32'(state_out), 1);
        chk("hd_pop0_c6", 32'(pop_d0), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("hd_valid_c7", 32'(valid_out), 1);
        chk("hd_data_c7", 32'(data_out), 32'h15);
        chk("hd_cnt0", 32'(count_d0), 5);

        // 260 back-to-back D1 words saturate count_d1
        do_reset();
        for (int c = 0; c < 266; c++) begin
            drive(1'b0, 1'b0, 1'b1, (c >= 260), '0, DW'(c));
            if (c == 0) begin
                chk("sat_pop1_c0", 32'(pop_d1), 1);
                chk("sat_pop0_c0", 32'(pop_d0), 0);
            end
            if (c == 100) begin
                chk("sat_valid_c100", 32'(valid_out), 1);
                chk("sat_dest_c100", 32'(dest_out), 1);
                chk("sat_data_c100", 32'(data_out), 35);
            end
            if (c == 255) chk("sat_cnt1_254", 32'(count_d1), 254);
            if (c == 256) chk("sat_cnt1_255", 32'(count_d1), 255);
        end
        chk("sat_cnt1_stays", 32'(count_d1), 255);
        chk("sat_cnt0", 32'(count_d0), 0);

        // Reset pulsed the cycle after a pop discards the in-flight word
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("mr_pop0", 32'(pop_d0), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h3F, '0);
        chk("mr_pop0_rst", 32'(pop_d0), 0);
        chk("mr_pop1_rst", 32'(pop_d1), 0);
        chk("mr_state_rst", 32'(state_out), 0);
        chk("mr_cnt0_rst", 32'(count_d0), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("mr_valid_c2", 32'(valid_out), 0);
        chk("mr_pop0_first", 32'(pop_d0), 1);
        chk("mr_pop1_first", 32'(pop_d1), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 6'h07, '0);
        chk("mr_valid_c3", 32'(valid_out), 0);
        chk("mr_cnt0_c3", 32'(count_d0), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        chk("mr_valid_c4", 32'(valid_out), 1);
        chk("mr_data_c4", 32'(data_out), 32'h07);
        chk("mr_cnt0_c4", 32'(count_d0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/d_fifo_sink.md
D_FIFO_SINK -- requirements
Module: d_fifo_sink

Interface
Parameters (name, default, meaning):
REQ-001 SHALL define DATA_WIDTH, 6, width of each destination FIFO data word.
REQ-002 SHALL define CNT_WIDTH, 8, width of each per-channel word counter.
Ports (name, direction, width, meaning):
REQ-003 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have reset, input, 1, asynchronous active-high reset; one clock, reset is asynchronous and active-high.
REQ-005 SHALL have fifo_empty_d0 and fifo_empty_d1, input, 1 each, empty flags of the D0 and D1 destination FIFOs.
REQ-006 SHALL have data_out_0 and data_out_1, input, DATA_WIDTH each, D0 and D1 FIFO read data, valid the cycle after the matching pop.
REQ-007 SHALL have hold, input, 1, consumer stall; while high no new pop is issued.
REQ-008 SHALL have pop_d0 and pop_d1, output, 1 each, pop strobes to the D0 and D1 FIFOs.
REQ-009 SHALL have data_out, output, DATA_WIDTH, captured word.
REQ-010 SHALL have valid_out, output, 1, data_out/dest_out valid this cycle.
REQ-011 SHALL have dest_out, output, 1, source channel of data_out (0 = D0, 1 = D1).
REQ-012 SHALL have count_d0 and count_d1, output, CNT_WIDTH each, words captured per channel.
REQ-013 SHALL have state_out, output, 2, FSM state (IDLE=00, ACTIVE=01, PAUSED=10).

Function
REQ-014 SHALL assert at most one of pop_d0/pop_d1 in any cycle.
REQ-015 SHALL drive pop_d0/pop_d1 combinationally: pop_dX = !reset & !hold & !fifo_empty_dX & grant_dX, from current-cycle inputs.
REQ-016 SHALL grant round-robin: both non-empty -> channel not served last; one non-empty -> that channel; none -> no grant.
REQ-017 SHALL update the last-served pointer only in a cycle with a pop; after reset it points to D1, so D0 wins the first tie.
REQ-018 SHALL register a pending flag and pending channel in the pop cycle (cycle N).
REQ-019 SHALL in cycle N+1 capture data_out_<pending channel> into data_out, set dest_out to that channel, and register valid_out=1 so it is high in cycle N+2.
REQ-020 SHALL sustain one word per cycle with back-to-back pops; valid_out stays high continuously during streaming.
REQ-021 SHALL complete an in-flight capture even if hold rises in the cycle after the pop; hold blocks only new pops.
REQ-022 SHALL hold data_out and dest_out at last captured values when valid_out is low.
REQ-023 SHALL increment count_dX by 1 on each capture from channel X, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-024 SHALL run FSM: IDLE -> ACTIVE when a pop is issued; ACTIVE -> PAUSED when hold=1; PAUSED -> ACTIVE when hold=0 and a FIFO is non-empty; PAUSED -> IDLE when hold=0, both empty, no pending; ACTIVE -> IDLE when no pop, no pending, both empty.
REQ-025 SHALL never issue a pop to a channel whose empty flag is high in that cycle.

Reset
REQ-026 SHALL on reset asserted (asynchronously) force pop_d0=pop_d1=0, valid_out=0, data_out=0, dest_out=0, count_d0=count_d1=0, state_out=IDLE, pending cleared, last-served=D1.
REQ-027 SHALL discard any in-flight capture when reset asserts mid-operation; the first pop after deassertion happens on the first rising edge with reset low.

Verification
REQ-028 SHALL verify reset: reset=1 with both FIFOs non-empty -> pops 0, all outputs at REQ-026 values.
REQ-029 SHALL verify single word: D0 non-empty one cycle, data_out_0=6'b101100 next cycle -> pop_d0 one cycle, valid_out two cycles later with data_out=6'b101100, dest_out=0, count_d0=1.
REQ-030 SHALL verify arbitration: both non-empty 6 cycles -> pops D0,D1,D0,D1,D0,D1; count_d0=count_d1=3.
REQ-031 SHALL verify hold: hold=1 for 4 cycles mid-stream -> no pops, state_out=PAUSED, pending word still output once; resumes on hold=0.
REQ-032 SHALL verify saturation: 260 D1 words -> count_d1=255 and stays.
REQ-033 SHALL verify reset mid-stream: reset pulsed the cycle after a pop -> no valid_out for that word, counters 0, state IDLE.
